// File: rtl/picorv32_pcpi_div_arb.sv
// picorv32_pcpi_div_arb: shares one PCPI divider between NREQ requesters.
// Decodes DIV/DIVU/REM/REMU, grants one requester at a time, holds the captured
// request at the divider and returns the result as a one-cycle req_ready pulse.
// Optional feature macro: PCPI_DIV_ARB_RR_EN selects round-robin arbitration;
// when undefined, arbitration is fixed priority with index 0 highest.
module picorv32_pcpi_div_arb #(
  parameter int unsigned NREQ = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [32*NREQ-1:0]   req_insn,
  input  logic [32*NREQ-1:0]   req_rs1,
  input  logic [32*NREQ-1:0]   req_rs2,
  output logic [NREQ-1:0]      req_wr,
  output logic [32*NREQ-1:0]   req_rd,
  output logic [NREQ-1:0]      req_wait,
  output logic [NREQ-1:0]      req_ready,
  output logic                 div_valid,
  output logic [31:0]          div_insn,
  output logic [31:0]          div_rs1,
  output logic [31:0]          div_rs2,
  input  logic                 div_wr,
  input  logic [31:0]          div_rd,
  input  logic                 div_ready,
  input  logic                 div_wait
);

  localparam int unsigned IDX_W = $clog2(NREQ);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [NREQ-1:0]    hit;
  logic [NREQ-1:0]    owner_oh;
  logic               owner_valid;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic               aborted_q, aborted_d;
  logic               gnt_any;
  logic [IDX_W-1:0]   gnt_idx;
  logic               lo_any;
  logic [IDX_W-1:0]   lo_idx;

  logic               div_valid_d;
  logic [31:0]        div_insn_d, div_rs1_d, div_rs2_d;
  logic [NREQ-1:0]    req_wr_d, req_wait_d, req_ready_d;
  logic [32*NREQ-1:0] req_rd_d;

`ifdef PCPI_DIV_ARB_RR_EN
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic               hi_any;
  logic [IDX_W-1:0]   hi_idx;
`endif

  // The divider's busy indication is not needed; wait is generated here.
  logic unused_div_wait;
  assign unused_div_wait = div_wait;

  // Decode: valid R-type with funct7=0000001 and funct3[2]=1 (DIV/DIVU/REM/REMU).
  always_comb begin
    hit = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      hit[k] = req_valid[k]
            && (req_insn[32*k +: 7] == 7'b0110011)
            && (req_insn[32*k+25 +: 7] == 7'b0000001)
            && req_insn[32*k+14];
    end
  end

  // Grant selection: lowest hit overall, or lowest hit strictly above the pointer.
  always_comb begin
    lo_any = 1'b0;
    lo_idx = '0;
`ifdef PCPI_DIV_ARB_RR_EN
    hi_any = 1'b0;
    hi_idx = '0;
`endif
    for (int k = int'(NREQ) - 1; k >= 0; k--) begin
      if (hit[k]) begin
        lo_any = 1'b1;
        lo_idx = IDX_W'(k);
`ifdef PCPI_DIV_ARB_RR_EN
        if (IDX_W'(k) > ptr_q) begin
          hi_any = 1'b1;
          hi_idx = IDX_W'(k);
        end
`endif
      end
    end
    gnt_any = lo_any;
`ifdef PCPI_DIV_ARB_RR_EN
    gnt_idx = hi_any ? hi_idx : lo_idx;
`else
    gnt_idx = lo_idx;
`endif
  end

  // Owner index as a one-hot mask, plus the owner's current valid.
  always_comb begin
    owner_oh    = '0;
    owner_valid = 1'b0;
    for (int k = 0; k < int'(NREQ); k++) begin
      if (owner_q == IDX_W'(k)) begin
        owner_oh[k] = 1'b1;
        owner_valid = req_valid[k];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; an aborted op skips RESP and goes straight to GAP.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (gnt_any) state_d = ST_BUSY;
      ST_BUSY: begin
        if (div_ready) begin
          state_d = (aborted_q || !owner_valid) ? ST_GAP : ST_RESP;
        end
      end
      ST_RESP: state_d = ST_GAP;
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic: next values for every registered output and context register.
  always_comb begin
    owner_d     = owner_q;
    aborted_d   = aborted_q;
    div_valid_d = div_valid;
    div_insn_d  = div_insn;
    div_rs1_d   = div_rs1;
    div_rs2_d   = div_rs2;
    req_ready_d = '0;
    req_wr_d    = '0;
    req_rd_d    = '0;
`ifdef PCPI_DIV_ARB_RR_EN
    ptr_d       = ptr_q;
`endif
    // Owner's wait is dropped while its response and the following gap are out.
    if (state_d == ST_RESP || state_d == ST_GAP) begin
      req_wait_d = hit & ~owner_oh;
    end else begin
      req_wait_d = hit;
    end

    case (state_q)
      ST_IDLE: begin
        if (gnt_any) begin
          owner_d     = gnt_idx;
          aborted_d   = 1'b0;
          div_valid_d = 1'b1;
          for (int k = 0; k < int'(NREQ); k++) begin
            if (gnt_idx == IDX_W'(k)) begin
              div_insn_d = req_insn[32*k +: 32];
              div_rs1_d  = req_rs1[32*k +: 32];
              div_rs2_d  = req_rs2[32*k +: 32];
            end
          end
        end
      end
      ST_BUSY: begin
        if (!owner_valid) aborted_d = 1'b1;
        if (div_ready) begin
          div_valid_d = 1'b0;
          if (!aborted_q && owner_valid) begin
            req_ready_d = owner_oh;
            req_wr_d    = owner_oh & {NREQ{div_wr}};
            for (int k = 0; k < int'(NREQ); k++) begin
              if (owner_oh[k]) req_rd_d[32*k +: 32] = div_rd;
            end
          end
        end
      end
      ST_RESP: begin
`ifdef PCPI_DIV_ARB_RR_EN
        ptr_d = owner_q;
`endif
      end
      default: begin
      end
    endcase
  end

  // Output and context registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q   <= '0;
      aborted_q <= 1'b0;
      div_valid <= 1'b0;
      div_insn  <= '0;
      div_rs1   <= '0;
      div_rs2   <= '0;
      req_ready <= '0;
      req_wr    <= '0;
      req_rd    <= '0;
      req_wait  <= '0;
`ifdef PCPI_DIV_ARB_RR_EN
      ptr_q     <= IDX_W'(NREQ - 1);
`endif
    end else begin
      owner_q   <= owner_d;
      aborted_q <= aborted_d;
      div_valid <= div_valid_d;
      div_insn  <= div_insn_d;
      div_rs1   <= div_rs1_d;
      div_rs2   <= div_rs2_d;
      req_ready <= req_ready_d;
      req_wr    <= req_wr_d;
      req_rd    <= req_rd_d;
      req_wait  <= req_wait_d;
`ifdef PCPI_DIV_ARB_RR_EN
      ptr_q     <= ptr_d;
`endif
    end
  end

endmodule

// File: tb/tb_picorv32_pcpi_div_arb.sv
// Self-checking bench for picorv32_pcpi_div_arb with a behavioural divider stub.
`timescale 1ns/1ps
module tb_picorv32_pcpi_div_arb;
  localparam int unsigned NREQ = 3;
  localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset;
  logic [NREQ-1:0]      req_valid;
  logic [32*NREQ-1:0]   req_insn, req_rs1, req_rs2;
  logic [NREQ-1:0]      req_wr, req_wait, req_ready;
  logic [32*NREQ-1:0]   req_rd;
  logic                 div_valid;
  logic [31:0]          div_insn, div_rs1, div_rs2;
  logic                 div_wr, div_ready, div_wait;
  logic [31:0]          div_rd;

  picorv32_pcpi_div_arb #(.NREQ(NREQ)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_insn(req_insn), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .req_wr(req_wr), .req_rd(req_rd), .req_wait(req_wait), .req_ready(req_ready),
    .div_valid(div_valid), .div_insn(div_insn), .div_rs1(div_rs1), .div_rs2(div_rs2),
    .div_wr(div_wr), .div_rd(div_rd), .div_ready(div_ready), .div_wait(div_wait)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // RISC-V M-extension division semantics, from the ISA rules.
  function automatic logic [31:0] ref_div(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic ovf;
    sa = a;
    sb = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      F_DIV:   return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
      F_DIVU:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
      F_REM:   return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Divider stub: starts on a rising div_valid, answers after a random delay.
  logic stub_busy, stub_vq, spur_ready;
  int   stub_cnt;
  assign div_wait = stub_busy;
  always @(posedge clk) begin
    if (reset) begin
      stub_busy <= 1'b0; stub_vq <= 1'b0; stub_cnt <= 0;
      div_ready <= 1'b0; div_wr <= 1'b0; div_rd <= '0;
    end else begin
      stub_vq   <= div_valid;
      div_ready <= 1'b0;
      div_wr    <= 1'b0;
      if (!stub_busy && div_valid && !stub_vq) begin
        stub_busy <= 1'b1;
        stub_cnt  <= int'($urandom_range(30, 6));
      end else if (stub_busy) begin
        if (stub_cnt == 0) begin
          stub_busy <= 1'b0;
          div_ready <= 1'b1;
          div_wr    <= 1'b1;
          div_rd    <= ref_div(div_insn[14:12], div_rs1, div_rs2);
        end else begin
          stub_cnt <= stub_cnt - 1;
        end
      end
      if (spur_ready) begin
        div_ready <= 1'b1;
        div_wr    <= 1'b1;
        div_rd    <= 32'hDEAD_BEEF;
      end
    end
  end

  // Reference model state: pending requests, expected results, last served index.
  logic [NREQ-1:0] pend;
  logic [31:0]     exp_rd [NREQ];
  int              rr_ptr;
  int              pulses [NREQ];

  function automatic int model_pick(input logic [NREQ-1:0] p);
    int best, bestd, d;
    best = -1;
    bestd = int'(NREQ) + 1;
    for (int k = 0; k < int'(NREQ); k++) begin
      if (p[k]) begin
`ifdef PCPI_DIV_ARB_RR_EN
        d = (k - rr_ptr - 1 + 2 * int'(NREQ)) % int'(NREQ);
`else
        d = k;
`endif
        if (d < bestd) begin bestd = d; best = k; end
      end
    end
    return best;
  endfunction

  function automatic logic [31:0] mk_insn(input logic [2:0] f3, input logic [6:0] f7);
    return {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
  endfunction

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(4, 0))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(20, 0));
      default: return $urandom;
    endcase
  endfunction

  function automatic int pulse_sum();
    int s = 0;
    for (int k = 0; k < int'(NREQ); k++) s += pulses[k];
    return s;
  endfunction

  task automatic tick();
    @(negedge clk);
    for (int k = 0; k < int'(NREQ); k++) if (req_ready[k]) pulses[k]++;
  endtask

  task automatic issue(input int k, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    req_insn[32*k +: 32] = mk_insn(f3, 7'b0000001);
    req_rs1[32*k +: 32]  = a;
    req_rs2[32*k +: 32]  = b;
    req_valid[k]         = 1'b1;
    exp_rd[k]            = ref_div(f3, a, b);
    pend[k]              = 1'b1;
  endtask

  task automatic issue_rand(input int k);
    issue(k, 3'(4 + $urandom_range(3, 0)), rnd_op(), rnd_op());
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0;
    pend = '0;
    tick();
    tick();
    reset = 1'b0;
    rr_ptr = int'(NREQ) - 1;
  endtask

  task automatic wait_pulse(input int budget, output int j);
    j = -1;
    for (int c = 0; c < budget && j < 0; c++) begin
      tick();
      for (int k = 0; k < int'(NREQ); k++) if (req_ready[k]) j = k;
    end
  endtask

  // Single uncontended op with wait/latency/pulse checks.
  task automatic run_op(input string tag, input int k, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b);
    int j, lat, p0;
    logic wait_ok;
    logic [32*NREQ-1:0] others;
    p0 = pulses[k];
    issue(k, f3, a, b);
    wait_ok = 1'b1;
    j = -1;
    lat = 0;
    while (j < 0 && lat < 50) begin
      tick();
      lat++;
      for (int m = 0; m < int'(NREQ); m++) if (req_ready[m]) j = m;
      if (j < 0 && !req_wait[k]) wait_ok = 1'b0;
    end
    others = req_rd;
    others[32*k +: 32] = '0;
    check({tag, "_served"}, 32'(j), 32'(k));
    check({tag, "_rd"}, req_rd[32*k +: 32], exp_rd[k]);
    check({tag, "_wr"}, 32'(req_wr[k]), 32'd1);
    check({tag, "_wait_hold"}, 32'(wait_ok), 32'd1);
    check({tag, "_wait_low"}, 32'(req_wait[k]), 32'd0);
    check({tag, "_rd_others"}, 32'(others != '0), 32'd0);
    check({tag, "_latency"}, 32'(lat <= 40), 32'd1);
    req_valid[k] = 1'b0;
    pend[k] = 1'b0;
    if (j >= 0) rr_ptr = j;
    tick();
    tick();
    check({tag, "_one_pulse"}, 32'(pulses[k] - p0), 32'd1);
  endtask

  // Serve every pending request, checking winner order against the model.
  task automatic serve_all(input int adds);
    int j, exp_j, guard;
    guard = 0;
    while (pend != '0 && guard < 20) begin
      guard++;
      exp_j = model_pick(pend);
      wait_pulse(60, j);
      check("arb_winner", 32'(j), 32'(exp_j));
      if (j < 0) begin
        req_valid = '0;
        pend = '0;
        return;
      end
      check("arb_rd", req_rd[32*j +: 32], exp_rd[j]);
      check("arb_wr", 32'(req_wr[j]), 32'd1);
      check("arb_wait", 32'(req_wait), 32'(pend & ~(NREQ'(1) << j)));
      rr_ptr = j;
      req_valid[j] = 1'b0;
      pend[j] = 1'b0;
      for (int k = 0; k < int'(NREQ); k++) begin
        if (adds > 0 && k != j && !pend[k] && $urandom_range(1, 0) == 1) begin
          issue_rand(k);
          adds--;
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int j, exp_j, p0, t_found;
    logic bad;
    reset = 1'b1;
    req_valid = '0; req_insn = '0; req_rs1 = '0; req_rs2 = '0;
    spur_ready = 1'b0;
    pend = '0;
    for (int k = 0; k < int'(NREQ); k++) begin pulses[k] = 0; exp_rd[k] = '0; end
    do_reset();

    // Reset values
    check("rst_div_valid", 32'(div_valid), 32'd0);
    check("rst_req_flags", 32'({req_wait, req_ready, req_wr}), 32'd0);
    check("rst_req_rd", 32'(req_rd != '0), 32'd0);
    check("rst_div_data", div_insn | div_rs1 | div_rs2, 32'd0);

    // Directed single ops
    run_op("div_m7_2", 0, F_DIV, 32'hFFFF_FFF9, 32'd2);
    run_op("remu_100_7", 1, F_REMU, 32'd100, 32'd7);
    run_op("divu_5_0", 1, F_DIVU, 32'd5, 32'd0);
    run_op("rem_m9_0", 1, F_REM, 32'hFFFF_FFF7, 32'd0);
    run_op("div_ovf", 2, F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);

    // Simultaneous DIVU from req0 and req1, then a repeat by req0
    do_reset();
    issue(0, F_DIVU, 32'd1000, 32'd10);
    issue(1, F_DIVU, 32'd999, 32'd9);
    wait_pulse(60, j);
    check("rr_first", 32'(j), 32'd0);
    check("rr_first_rd", req_rd[31:0], 32'd100);
    if (j >= 0) begin rr_ptr = j; req_valid[j] = 1'b0; pend[j] = 1'b0; end
    tick();
    issue(0, F_DIVU, 32'd64, 32'd8);
    exp_j = model_pick(pend);
    wait_pulse(60, j);
    check("rr_repeat", 32'(j), 32'(exp_j));
    if (j >= 0) begin
      check("rr_repeat_rd", req_rd[32*j +: 32], exp_rd[j]);
      rr_ptr = j; req_valid[j] = 1'b0; pend[j] = 1'b0;
    end
    serve_all(0);

    // Non-divide instructions are ignored (MUL, and XOR with funct3=100)
    req_insn[31:0]  = mk_insn(3'b000, 7'b0000001);
    req_insn[63:32] = mk_insn(3'b100, 7'b0000000);
    req_valid[1:0]  = 2'b11;
    bad = 1'b0;
    for (int c = 0; c < 50; c++) begin
      tick();
      if (req_wait != '0 || req_ready != '0 || div_valid) bad = 1'b1;
    end
    check("ignore_non_div", 32'(bad), 32'd0);
    req_valid = '0;
    tick();

    // Abort: req0 drops valid 5 cycles into BUSY while req1 waits
    p0 = pulses[0];
    issue(0, F_DIVU, 32'd1000, 32'd7);
    tick();
    issue(1, F_DIVU, 32'd77, 32'd5);
    for (int c = 0; c < 4; c++) tick();
    req_valid[0] = 1'b0;
    pend[0] = 1'b0;
    t_found = 0;
    for (int c = 0; c < 50 && t_found == 0; c++) begin
      tick();
      if (div_ready) t_found = 1;
    end
    check("abort_div_ready_seen", 32'(t_found), 32'd1);
    tick();
    check("abort_no_resp", 32'({div_valid, req_ready}), 32'd0);
    tick();
    check("abort_gap", 32'(div_valid), 32'd0);
    tick();
    check("abort_regrant", 32'(div_valid), 32'd1);
    check("abort_regrant_rs1", div_rs1, 32'd77);
    wait_pulse(60, j);
    check("abort_req1_served", 32'(j), 32'd1);
    check("abort_req1_rd", req_rd[63:32], 32'd15);
    check("abort_no_pulse0", 32'(pulses[0] - p0), 32'd0);
    if (j >= 0) rr_ptr = j;
    req_valid[1] = 1'b0;
    pend[1] = 1'b0;
    tick();
    tick();

    // Reset for one cycle mid-BUSY
    issue(0, F_DIVU, 32'd50, 32'd3);
    for (int c = 0; c < 4; c++) tick();
    reset = 1'b1;
    req_valid = '0;
    pend = '0;
    tick();
    reset = 1'b0;
    rr_ptr = int'(NREQ) - 1;
    check("midrst_flags", 32'({div_valid, req_wait, req_ready, req_wr}), 32'd0);
    check("midrst_req_rd", 32'(req_rd != '0), 32'd0);
    check("midrst_div_data", div_insn | div_rs1 | div_rs2, 32'd0);
    p0 = pulse_sum();
    for (int c = 0; c < 45; c++) tick();
    check("midrst_no_pulse", 32'(pulse_sum() - p0), 32'd0);
    run_op("divu_10_3", 0, F_DIVU, 32'd10, 32'd3);

    // A div_ready outside BUSY is ignored
    p0 = pulse_sum();
    spur_ready = 1'b1;
    tick();
    spur_ready = 1'b0;
    tick();
    tick();
    tick();
    check("spurious_ready", 32'(pulse_sum() - p0), 32'd0);
    check("spurious_idle", 32'(div_valid), 32'd0);

    // Randomised contention
    for (int r = 0; r < 10; r++) begin
      int n_new;
      n_new = 0;
      for (int k = 0; k < int'(NREQ); k++) begin
        if ($urandom_range(1, 0) == 1) begin issue_rand(k); n_new++; end
      end
      if (n_new == 0) issue_rand(int'($urandom_range(NREQ - 1, 0)));
      serve_all(3);
      tick();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
